fp_operand_join: RTL

FP_OPERAND_JOIN -- requirements
Module: fp_operand_join

---
 rtl/fp_operand_join.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fp_operand_join.sv
// Pairs single-precision operands from two independent AXI-Stream lanes for the FP adder.
// Each lane is buffered in a small FIFO; one registered output slot presents the pair plus exponent flags.
module fp_operand_join #(
   parameter int DATA  = 32,
   parameter int DEPTH = 4
) (
   input  logic                    axis_clk,
   input  logic                    axis_reset,
   input  logic                    s_axis_valid_a,
   output logic                    s_axis_ready_a,
   input  logic [DATA-1:0]         s_axis_data_a,
   input  logic                    s_axis_valid_b,
   output logic                    s_axis_ready_b,
   input  logic [DATA-1:0]         s_axis_data_b,
   output logic                    m_axis_valid,
   input  logic                    m_axis_ready,
   output logic [DATA-1:0]         m_axis_data_a,
   output logic [DATA-1:0]         m_axis_data_b,
   output logic [3:0]              m_axis_flags,
   output logic [$clog2(DEPTH):0]  count_a,
   output logic [$clog2(DEPTH):0]  count_b
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DATA-1:0] mem_a_q [DEPTH];
   logic [DATA-1:0] mem_a_d [DEPTH];
   logic [DATA-1:0] mem_b_q [DEPTH];
   logic [DATA-1:0] mem_b_d [DEPTH];
   logic [AW-1:0]   wr_a_q, wr_a_d, rd_a_q, rd_a_d;
   logic [AW-1:0]   wr_b_q, wr_b_d, rd_b_q, rd_b_d;
   logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic            out_valid_q, out_valid_d;
   logic [DATA-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic [3:0]      flags_q, flags_d;

   logic            push_a, push_b, pop;
   logic [DATA-1:0] head_a, head_b;
   logic [1:0]      cls_a, cls_b;

   // {exponent all ones, exponent zero}
   function automatic logic [1:0] exp_class(input logic [DATA-1:0] v);
      return {v[30:23] == 8'hFF, v[30:23] == 8'h00};
   endfunction

   // Ready depends only on occupancy and reset, never on the output side.
   assign s_axis_ready_a = (cnt_a_q < FULL) && !axis_reset;
   assign s_axis_ready_b = (cnt_b_q < FULL) && !axis_reset;

   assign push_a = s_axis_valid_a && s_axis_ready_a;
   assign push_b = s_axis_valid_b && s_axis_ready_b;
   assign pop    = (cnt_a_q != '0) && (cnt_b_q != '0) && (!out_valid_q || m_axis_ready);

   assign head_a = mem_a_q[rd_a_q];
   assign head_b = mem_b_q[rd_b_q];
   assign cls_a  = exp_class(head_a);
   assign cls_b  = exp_class(head_b);

   assign m_axis_valid  = out_valid_q;
   assign m_axis_data_a = out_a_q;
   assign m_axis_data_b = out_b_q;
   assign m_axis_flags  = flags_q;
   assign count_a       = cnt_a_q;
   assign count_b       = cnt_b_q;

   always_comb begin
      mem_a_d = mem_a_q;
      mem_b_d = mem_b_q;
      wr_a_d  = wr_a_q;
      wr_b_d  = wr_b_q;
      rd_a_d  = rd_a_q;
      rd_b_d  = rd_b_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;

      if (push_a) begin
         mem_a_d[wr_a_q] = s_axis_data_a;
         wr_a_d          = wr_a_q + 1'b1;
      end
      if (push_b) begin
         mem_b_d[wr_b_q] = s_axis_data_b;
         wr_b_d          = wr_b_q + 1'b1;
      end
      if (pop) begin
         rd_a_d = rd_a_q + 1'b1;
         rd_b_d = rd_b_q + 1'b1;
      end

      case ({push_a, pop})
         2'b10:   cnt_a_d = cnt_a_q + 1'b1;
         2'b01:   cnt_a_d = cnt_a_q - 1'b1;
         default: cnt_a_d = cnt_a_q;
      endcase
      case ({push_b, pop})
         2'b10:   cnt_b_d = cnt_b_q + 1'b1;
         2'b01:   cnt_b_d = cnt_b_q - 1'b1;
         default: cnt_b_d = cnt_b_q;
      endcase
   end

   // Output slot: data and flags only change on a pop, so they hold under stall and after drain.
   always_comb begin
      out_valid_d = out_valid_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      flags_d     = flags_q;
      if (pop) begin
         out_valid_d = 1'b1;
         out_a_d     = head_a;
         out_b_d     = head_b;
         flags_d     = {cls_b[1], cls_a[1], cls_b[0], cls_a[0]};
      end else if (m_axis_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge axis_clk or posedge axis_reset) begin
      if (axis_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_a_q[i] <= '0;
            mem_b_q[i] <= '0;
         end
         wr_a_q      <= '0;
         wr_b_q      <= '0;
         rd_a_q      <= '0;
         rd_b_q      <= '0;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         flags_q     <= '0;
      end else begin
         mem_a_q     <= mem_a_d;
         mem_b_q     <= mem_b_d;
         wr_a_q      <= wr_a_d;
         wr_b_q      <= wr_b_d;
         rd_a_q      <= rd_a_d;
         rd_b_q      <= rd_b_d;
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         out_valid_q <= out_valid_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         flags_q     <= flags_d;
      end
   end

endmodule
